// File: rtl/wb_serial_tl_bridge_if.sv
// Bus bundle for the Wishbone / serial TileLink bridge.
// Holds the Wishbone slave signals plus both serial_tl channels and the irq.
interface wb_serial_tl_bridge_if #(
  parameter int W = 32
) ();
  logic         wbs_stb_i;
  logic         wbs_cyc_i;
  logic         wbs_we_i;
  logic [3:0]   wbs_sel_i;
  logic [31:0]  wbs_adr_i;
  logic [31:0]  wbs_dat_i;
  logic         wbs_ack_o;
  logic [31:0]  wbs_dat_o;
  logic [W-1:0] tl_in_bits;
  logic         tl_in_valid;
  logic         tl_in_ready;
  logic [W-1:0] tl_out_bits;
  logic         tl_out_valid;
  logic         tl_out_ready;
  logic         irq_o;

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o,
    output tl_in_bits, tl_in_valid,
    input  tl_in_ready,
    input  tl_out_bits, tl_out_valid,
    output tl_out_ready,
    output irq_o
  );

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o,
    input  tl_in_bits, tl_in_valid,
    output tl_in_ready,
    output tl_out_bits, tl_out_valid,
    input  tl_out_ready,
    input  irq_o
  );
endinterface

// File: rtl/wb_serial_tl_bridge.sv
// Wishbone slave bridging the management bus to the serial TileLink port.
// Bus writes feed a TX FIFO toward tl_in; tl_out words land in an RX FIFO the
// bus pops by reading. STATUS/CTRL registers and a level irq round it out.
module wb_serial_tl_bridge #(
  parameter int          W        = 32,
  parameter int          DEPTH    = 4,
  parameter logic [31:0] BASE_ADR = 32'h3000_0000
) (
  input logic                  wb_clk_i,
  input logic                  wb_rst_i,
  wb_serial_tl_bridge_if.slave bus
);

  localparam int         PW       = $clog2(DEPTH);
  localparam logic [3:0] CNT_FULL = 4'(DEPTH);

  localparam logic [1:0] OFF_TXDATA = 2'd0;
  localparam logic [1:0] OFF_RXDATA = 2'd1;
  localparam logic [1:0] OFF_STATUS = 2'd2;
  localparam logic [1:0] OFF_CTRL   = 2'd3;

  // Pack the STATUS word from the individual flags and counts.
  function automatic logic [31:0] pack_status(
    input logic       tx_full,
    input logic       tx_empty,
    input logic       rx_full,
    input logic       rx_empty,
    input logic       tx_ovf,
    input logic       rx_udf,
    input logic [3:0] tx_cnt,
    input logic [3:0] rx_cnt
  );
    return {16'h0000, rx_cnt, tx_cnt, 2'b00, rx_udf, tx_ovf,
            rx_empty, rx_full, tx_empty, tx_full};
  endfunction

  // Registered state
  logic          ack_q, ack_d;
  logic [31:0]   dat_q, dat_d;
  logic          irq_q, irq_d;
  logic          tx_ovf_q, tx_ovf_d;
  logic          rx_udf_q, rx_udf_d;
  logic [3:0]    tx_cnt_q, tx_cnt_d;
  logic [3:0]    rx_cnt_q, rx_cnt_d;
  logic [PW-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic [PW-1:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic [W-1:0]  tx_mem_q [DEPTH];
  logic [W-1:0]  tx_mem_d [DEPTH];
  logic [W-1:0]  rx_mem_q [DEPTH];
  logic [W-1:0]  rx_mem_d [DEPTH];

  // Decoded events for the current cycle
  logic          hit_s, req_s, wr_s, rd_s;
  logic [1:0]    off_s;
  logic          tx_full_s, tx_empty_s, rx_full_s, rx_empty_s;
  logic          tx_push_req_s, tx_push_s, tx_pop_s, tx_ovf_set_s;
  logic          rx_ready_s, rx_push_s, rx_pop_req_s, rx_pop_s, rx_udf_set_s;
  logic          ctrl_wr_s, clr_s, flush_s;
  logic [31:0]   rx_head_ext_s;
  logic          unused_s;

  assign unused_s = ^{bus.wbs_adr_i[1:0], bus.wbs_dat_i};

  // Decode the bus request and the FIFO handshakes from registered counts.
  always_comb begin
    hit_s         = (bus.wbs_adr_i[31:4] == BASE_ADR[31:4]);
    req_s         = bus.wbs_stb_i & bus.wbs_cyc_i & hit_s & ~ack_q;
    off_s         = bus.wbs_adr_i[3:2];
    wr_s          = req_s & bus.wbs_we_i;
    rd_s          = req_s & ~bus.wbs_we_i;

    tx_full_s     = (tx_cnt_q == CNT_FULL);
    tx_empty_s    = (tx_cnt_q == 4'd0);
    rx_full_s     = (rx_cnt_q == CNT_FULL);
    rx_empty_s    = (rx_cnt_q == 4'd0);

    tx_push_req_s = wr_s & (off_s == OFF_TXDATA) & (bus.wbs_sel_i == 4'hF);
    // Fullness is judged on the start-of-cycle count, so a same-cycle pop
    // does not rescue a push into a full FIFO.
    tx_push_s     = tx_push_req_s & ~tx_full_s;
    tx_ovf_set_s  = tx_push_req_s & tx_full_s;
    tx_pop_s      = ~tx_empty_s & bus.tl_in_ready;

    rx_ready_s    = ~rx_full_s & ~wb_rst_i;
    rx_push_s     = bus.tl_out_valid & rx_ready_s;
    rx_pop_req_s  = rd_s & (off_s == OFF_RXDATA);
    rx_pop_s      = rx_pop_req_s & ~rx_empty_s;
    rx_udf_set_s  = rx_pop_req_s & rx_empty_s;

    ctrl_wr_s     = wr_s & (off_s == OFF_CTRL) & bus.wbs_sel_i[0];
    clr_s         = ctrl_wr_s & bus.wbs_dat_i[0];
    flush_s       = ctrl_wr_s & bus.wbs_dat_i[1];

    rx_head_ext_s          = 32'h0000_0000;
    rx_head_ext_s[W-1:0]   = rx_mem_q[rx_rd_q];
  end

  // TX FIFO next state: push from the bus, pop on the tl_in handshake, flush wins.
  always_comb begin
    tx_mem_d = tx_mem_q;
    tx_wr_d  = tx_wr_q;
    tx_rd_d  = tx_rd_q;
    tx_cnt_d = tx_cnt_q;
    if (tx_push_s) begin
      tx_mem_d[tx_wr_q] = bus.wbs_dat_i[W-1:0];
      tx_wr_d           = tx_wr_q + PW'(1);
    end else begin
      tx_wr_d = tx_wr_q;
    end
    if (tx_pop_s) begin
      tx_rd_d = tx_rd_q + PW'(1);
    end else begin
      tx_rd_d = tx_rd_q;
    end
    case ({tx_push_s, tx_pop_s})
      2'b10:   tx_cnt_d = tx_cnt_q + 4'd1;
      2'b01:   tx_cnt_d = tx_cnt_q - 4'd1;
      default: tx_cnt_d = tx_cnt_q;
    endcase
    if (flush_s) begin
      tx_wr_d  = {PW{1'b0}};
      tx_rd_d  = {PW{1'b0}};
      tx_cnt_d = 4'd0;
    end else begin
      tx_cnt_d = tx_cnt_d;
    end
  end

  // RX FIFO next state: push on the tl_out handshake, pop by bus read; a word
  // accepted in a flush cycle is dropped with the rest of the contents.
  always_comb begin
    rx_mem_d = rx_mem_q;
    rx_wr_d  = rx_wr_q;
    rx_rd_d  = rx_rd_q;
    rx_cnt_d = rx_cnt_q;
    if (rx_push_s) begin
      rx_mem_d[rx_wr_q] = bus.tl_out_bits;
      rx_wr_d           = rx_wr_q + PW'(1);
    end else begin
      rx_wr_d = rx_wr_q;
    end
    if (rx_pop_s) begin
      rx_rd_d = rx_rd_q + PW'(1);
    end else begin
      rx_rd_d = rx_rd_q;
    end
    case ({rx_push_s, rx_pop_s})
      2'b10:   rx_cnt_d = rx_cnt_q + 4'd1;
      2'b01:   rx_cnt_d = rx_cnt_q - 4'd1;
      default: rx_cnt_d = rx_cnt_q;
    endcase
    if (flush_s) begin
      rx_wr_d  = {PW{1'b0}};
      rx_rd_d  = {PW{1'b0}};
      rx_cnt_d = 4'd0;
    end else begin
      rx_cnt_d = rx_cnt_d;
    end
  end

  // Bus response, sticky flags and interrupt next state.
  always_comb begin
    ack_d = req_s;
    dat_d = 32'h0000_0000;
    if (rd_s) begin
      case (off_s)
        OFF_RXDATA: dat_d = rx_empty_s ? 32'h0000_0000 : rx_head_ext_s;
        OFF_STATUS: dat_d = pack_status(tx_full_s, tx_empty_s, rx_full_s,
                                        rx_empty_s, tx_ovf_q, rx_udf_q,
                                        tx_cnt_q, rx_cnt_q);
        default:    dat_d = 32'h0000_0000;
      endcase
    end else begin
      dat_d = 32'h0000_0000;
    end
    // A new event in the same cycle as a clear keeps the flag set.
    tx_ovf_d = (tx_ovf_q & ~clr_s) | tx_ovf_set_s;
    rx_udf_d = (rx_udf_q & ~clr_s) | rx_udf_set_s;
    irq_d    = (rx_cnt_d != 4'd0);
  end

  // Control state register with synchronous reset.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_q    <= 1'b0;
      dat_q    <= 32'h0000_0000;
      irq_q    <= 1'b0;
      tx_ovf_q <= 1'b0;
      rx_udf_q <= 1'b0;
      tx_cnt_q <= 4'd0;
      rx_cnt_q <= 4'd0;
      tx_wr_q  <= {PW{1'b0}};
      tx_rd_q  <= {PW{1'b0}};
      rx_wr_q  <= {PW{1'b0}};
      rx_rd_q  <= {PW{1'b0}};
    end else begin
      ack_q    <= ack_d;
      dat_q    <= dat_d;
      irq_q    <= irq_d;
      tx_ovf_q <= tx_ovf_d;
      rx_udf_q <= rx_udf_d;
      tx_cnt_q <= tx_cnt_d;
      rx_cnt_q <= rx_cnt_d;
      tx_wr_q  <= tx_wr_d;
      tx_rd_q  <= tx_rd_d;
      rx_wr_q  <= rx_wr_d;
      rx_rd_q  <= rx_rd_d;
    end
  end

  // FIFO storage; contents are don't-care while the counts say empty.
  always_ff @(posedge wb_clk_i) begin
    tx_mem_q <= tx_mem_d;
    rx_mem_q <= rx_mem_d;
  end

  assign bus.wbs_ack_o    = ack_q;
  assign bus.wbs_dat_o    = dat_q;
  assign bus.irq_o        = irq_q;
  assign bus.tl_in_valid  = ~tx_empty_s;
  assign bus.tl_in_bits   = tx_mem_q[tx_rd_q];
  assign bus.tl_out_ready = rx_ready_s;

endmodule
